// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_adder
// Description : Pipelined two's-complement adder/subtractor with valid/ready
//               handshake. The WIDTH-bit carry-ripple add is cut into STAGES
//               slices of WIDTH/STAGES bits, one slice per register stage.
//               Produces sum, carry-out, signed overflow and zero flags.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               in_valid   - operand beat present
//               in_ready   - block accepts a beat this cycle
//               a, b       - operands (WIDTH bits)
//               sub        - 0: a+b, 1: a-b (a + ~b + 1)
//               out_valid  - result beat present
//               out_ready  - downstream accepts the result this cycle
//               sum        - result modulo 2^WIDTH
//               cout       - carry out of MSB (for sub: 1 = no borrow)
//               ovf        - signed overflow
//               zero       - sum == 0
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_CHUNK = WIDTH / STAGES;

    logic [STAGES-1:0] r_v;
    logic [STAGES:0]   w_ready;

    // A stage may load when it is empty or its content is leaving; the
    // chain lets bubbles collapse while the output is stalled.
    always_comb begin
        w_ready         = '0;
        w_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = ~r_v[k] | w_ready[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
        end else begin
            if (w_ready[0]) begin
                r_v[0] <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_v[k] <= r_v[k-1];
                end
            end
        end
    end

    assign in_ready  = w_ready[0];
    assign out_valid = r_v[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_LO = k * c_CHUNK;     // lowest bit of this slice
        localparam int c_BW = WIDTH - c_LO;    // b bits still pending here

        logic               w_v_up;
        logic [WIDTH-1:0]   w_sa_up;
        logic [c_BW-1:0]    w_b_up;
        logic               w_c_up;
        logic [c_CHUNK-1:0] w_a_sl;
        logic [c_CHUNK-1:0] w_b_sl;
        logic [c_CHUNK:0]   w_add;
        logic [WIDTH-1:0]   w_sa_nx;
        logic               w_load;

        // r_sa holds finished sum bits below the next slice and the
        // still-unprocessed bits of a above it, so no bit is carried twice.
        logic [WIDTH-1:0]   r_sa;
        logic               r_c;

        if (k == 0) begin : g_src_in
            assign w_v_up  = in_valid;
            assign w_sa_up = a;
            assign w_b_up  = b ^ {WIDTH{sub}};
            assign w_c_up  = sub;
        end else begin : g_src_prev
            assign w_v_up  = r_v[k-1];
            assign w_sa_up = g_stage[k-1].r_sa;
            assign w_b_up  = g_stage[k-1].g_bpass.r_b;
            assign w_c_up  = g_stage[k-1].r_c;
        end

        assign w_a_sl = w_sa_up[c_LO +: c_CHUNK];
        assign w_b_sl = w_b_up[c_CHUNK-1:0];
        assign w_add  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{c_CHUNK{1'b0}}, w_c_up};
        assign w_load = w_v_up & w_ready[k];

        always_comb begin
            w_sa_nx                  = w_sa_up;
            w_sa_nx[c_LO +: c_CHUNK] = w_add[c_CHUNK-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sa <= '0;
                r_c  <= 1'b0;
            end else if (w_load) begin
                r_sa <= w_sa_nx;
                r_c  <= w_add[c_CHUNK];
            end
        end

        if (k < STAGES - 1) begin : g_bpass
            // Upper (already conditionally inverted) b slices still to add.
            logic [c_BW-c_CHUNK-1:0] r_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_b <= '0;
                end else if (w_load) begin
                    r_b <= w_b_up[c_BW-1:c_CHUNK];
                end
            end
        end else begin : g_last
            logic w_cmsb;
            logic r_ovf;

            // Carry into the MSB recovered from the MSB sum bit and its inputs.
            assign w_cmsb = w_add[c_CHUNK-1] ^ w_a_sl[c_CHUNK-1] ^ w_b_sl[c_CHUNK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_load) begin
                    r_ovf <= w_cmsb ^ w_add[c_CHUNK];
                end
            end

            assign sum  = r_sa;
            assign cout = r_c;
            assign ovf  = r_ovf;
            assign zero = (r_sa == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipe_adder
// Description : Scoreboard bench for pipe_adder (WIDTH=32, STAGES=4).
//               Stimulus pushes expected results into a queue; a monitor
//               pops and compares whenever a result beat is transferred.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             sub       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width add plus a separate 31-bit add for MSB carry-in.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        exp_t        e;
        logic [31:0] yy;
        logic [32:0] full;
        logic [31:0] low;
        yy        = s ? ~y : y;
        full      = {1'b0, x} + {1'b0, yy} + {32'd0, s};
        low       = {1'b0, x[30:0]} + {1'b0, yy[30:0]} + {31'd0, s};
        e.s       = full[31:0];
        e.c       = full[32];
        e.o       = low[31] ^ full[32];
        e.z       = (full[31:0] == 32'd0);
        e.cyc     = 0;
        e.chk_lat = 1'b1;
        return e;
    endfunction

    // Monitor: a beat transfers at the next edge when out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got sum %h with no beat pending (cycle %0d)", sum, cyc);
            end else begin
                m_e = q.pop_front();
                check("sum",  sum,         m_e.s);
                check("cout", {31'd0, cout}, {31'd0, m_e.c});
                check("ovf",  {31'd0, ovf},  {31'd0, m_e.o});
                check("zero", {31'd0, zero}, {31'd0, m_e.z});
                if (m_e.chk_lat) check("latency", 32'(cyc - m_e.cyc), 32'(STAGES));
            end
        end
    end

    // One cycle of stimulus; acc reports whether the beat is taken at the next edge.
    task automatic drive(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                         input logic ss, input logic ordy, output bit acc);
        @(posedge clk);
        #2;
        in_valid  = v;
        a         = aa;
        b         = bb;
        sub       = ss;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, acc);
    endtask

    task automatic send_dir(input logic [31:0] aa, input logic [31:0] bb, input logic ss,
                            input logic [31:0] es, input logic ec, input logic eo, input logic ez);
        bit   acc;
        exp_t e;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            drive(1'b1, aa, bb, ss, 1'b1, acc);
        end
        if (acc) begin
            e.s = es; e.c = ec; e.o = eo; e.z = ez; e.cyc = cyc; e.chk_lat = 1'b1;
            q.push_back(e);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0 for a=%h b=%h", aa, bb);
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 40 && q.size() != 0; t++) idle(1);
        idle(2);
        check("drained", 32'(q.size()), 32'd0);
    endtask

    logic [31:0] va [14];
    logic [31:0] vb [14];
    logic        vs [14];

    initial begin
        bit          acc;
        int          idx;
        bit          have_ref;
        logic [31:0] ref_s;
        logic        ref_c;
        logic        ref_o;
        exp_t        e;

        // ---------------- reset state ----------------
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",       sum,                32'd0);
        check("rst_cout",      {31'd0, cout},      32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_zero",      {31'd0, zero},      32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ---------------- directed vectors ----------------
        send_dir(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        wait_drain();
        send_dir(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send_dir(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        send_dir(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        send_dir(32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send_dir(32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        send_dir(32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send_dir(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        send_dir(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        send_dir(32'h0001_0000, 32'h0000_0001, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0);
        send_dir(32'h00FF_00FF, 32'h0001_FF01, 1'b0, 32'h0101_0000, 1'b0, 1'b0, 1'b0);
        send_dir(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // ---------------- back-to-back random stream ----------------
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            drive(1'b1, ra, rb, rs, 1'b1, acc);
            check("stream_in_ready", {31'd0, acc}, 32'd1);
            if (acc) begin
                e     = model(ra, rb, rs);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
        wait_drain();

        // ---------------- backpressure ----------------
        for (int i = 0; i < 14; i++) begin
            va[i] = $urandom;
            vb[i] = $urandom;
            vs[i] = 1'($urandom_range(0, 1));
        end
        idx      = 0;
        have_ref = 1'b0;
        ref_s    = '0;
        ref_c    = 1'b0;
        ref_o    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, va[idx], vb[idx], vs[idx], 1'b0, acc);
            if (acc) begin
                e         = model(va[idx], vb[idx], vs[idx]);
                e.chk_lat = 1'b0;
                q.push_back(e);
                idx++;
            end
            if (out_valid) begin
                if (!have_ref) begin
                    have_ref = 1'b1;
                    ref_s    = sum;
                    ref_c    = cout;
                    ref_o    = ovf;
                end else begin
                    check("stall_sum",  sum,           ref_s);
                    check("stall_cout", {31'd0, cout}, {31'd0, ref_c});
                    check("stall_ovf",  {31'd0, ovf},  {31'd0, ref_o});
                end
            end
        end
        check("stall_accepted", 32'(idx), 32'(STAGES));
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        for (int t = 0; t < 40 && idx < 14; t++) begin
            drive(1'b1, va[idx], vb[idx], vs[idx], 1'b1, acc);
            if (acc) begin
                e         = model(va[idx], vb[idx], vs[idx]);
                e.chk_lat = 1'b0;
                q.push_back(e);
                idx++;
            end
        end
        check("resume_accepted", 32'(idx), 32'd14);
        wait_drain();

        // ---------------- reset with beats in flight ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 32'h0000_1111, 1'b0, 1'b1, acc);
            if (acc) begin
                e     = model(32'hA000_0000 + 32'(i), 32'h0000_1111, 1'b0);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #2 in_valid = 1'b0;
        #1 rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum",       sum,                32'd0);
        check("midrst_zero",      {31'd0, zero},      32'd1);
        q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(8);
        send_dir(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 32'h0E0E_0E0E, 1'b1, 1'b0, 1'b0);
        wait_drain();

        check("final_queue_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (tests %0d, failed %0d)", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
